// File: rtl/subsistema_multiplicacion.sv
// rtl/subsistema_multiplicacion.sv - sequential shift-and-add multiplier fed by the read subsystem
//
// Optional feature macro: MULT_CON_SIGNO_EN (two's complement operands and product).
// When undefined the block is purely unsigned and carries no sign logic.

module subsistema_multiplicacion #(
    parameter int ANCHO = 4
) (
    input  logic                 reloj,
    input  logic                 reinicio,
    input  logic [ANCHO-1:0]     operandoA,
    input  logic [ANCHO-1:0]     operandoB,
    input  logic                 banderaValida,
    input  logic                 iniciarMultiplicacion,
    output logic [2*ANCHO-1:0]   producto,
    output logic                 banderaListo,
    output logic                 ocupado
);

    localparam int AC = 2 * ANCHO;
    localparam int CW = $clog2(ANCHO) + 1;
    localparam logic [CW-1:0] ULTIMO = CW'(ANCHO - 1);

    typedef enum logic [1:0] {
        ESPERA  = 2'd0,
        CALCULO = 2'd1,
        LISTO   = 2'd2
    } estado_t;

    estado_t          estado;
    estado_t          estadoSig;

    logic [AC-1:0]    multiplicando;
    logic [ANCHO-1:0] multiplicador;
    logic [AC-1:0]    acumulador;
    logic [CW-1:0]    contador;

    logic             arranque;
    logic             ultimoPaso;
    logic [ANCHO-1:0] magA;
    logic [ANCHO-1:0] magB;
    logic [AC-1:0]    sumaPaso;
    logic [AC-1:0]    productoFinal;

`ifdef MULT_CON_SIGNO_EN
    logic             signo;
    logic             signoSig;
`endif

    // A start only counts when the read subsystem vouches for the operands
    assign arranque   = iniciarMultiplicacion && banderaValida;
    assign ultimoPaso = (estado == CALCULO) && (contador == ULTIMO);

    // Operand conditioning at capture: magnitudes in signed mode, pass-through otherwise
    always_comb begin
`ifdef MULT_CON_SIGNO_EN
        magA     = operandoA[ANCHO-1] ? (~operandoA + {{(ANCHO-1){1'b0}}, 1'b1}) : operandoA;
        magB     = operandoB[ANCHO-1] ? (~operandoB + {{(ANCHO-1){1'b0}}, 1'b1}) : operandoB;
        signoSig = operandoA[ANCHO-1] ^ operandoB[ANCHO-1];
`else
        magA = operandoA;
        magB = operandoB;
`endif
    end

    // One partial-product step; the final step's sum feeds the product register directly
    always_comb begin
        sumaPaso = acumulador + (multiplicador[0] ? multiplicando : {AC{1'b0}});
`ifdef MULT_CON_SIGNO_EN
        productoFinal = signo ? (~sumaPaso + {{(AC-1){1'b0}}, 1'b1}) : sumaPaso;
`else
        productoFinal = sumaPaso;
`endif
    end

    // State register
    always_ff @(posedge reloj) begin
        if (!reinicio) begin
            estado <= ESPERA;
        end else begin
            estado <= estadoSig;
        end
    end

    // Next-state logic; LISTO waits for start to drop so a held level cannot retrigger
    always_comb begin
        estadoSig = estado;
        case (estado)
            ESPERA:  if (arranque)               estadoSig = CALCULO;
            CALCULO: if (ultimoPaso)             estadoSig = LISTO;
            LISTO:   if (!iniciarMultiplicacion) estadoSig = ESPERA;
            default:                             estadoSig = ESPERA;
        endcase
    end

    // Output decoding straight from the state register
    always_comb begin
        ocupado      = (estado == CALCULO);
        banderaListo = (estado == LISTO);
    end

    // Datapath: capture on start, shift-and-add while calculating, load product on last step
    always_ff @(posedge reloj) begin
        if (!reinicio) begin
            multiplicando <= '0;
            multiplicador <= '0;
            acumulador    <= '0;
            contador      <= '0;
            producto      <= '0;
`ifdef MULT_CON_SIGNO_EN
            signo         <= 1'b0;
`endif
        end else begin
            case (estado)
                ESPERA: begin
                    if (arranque) begin
                        multiplicando <= {{ANCHO{1'b0}}, magA};
                        multiplicador <= magB;
                        acumulador    <= '0;
                        contador      <= '0;
`ifdef MULT_CON_SIGNO_EN
                        signo         <= signoSig;
`endif
                    end
                end
                CALCULO: begin
                    acumulador    <= sumaPaso;
                    multiplicando <= multiplicando << 1;
                    multiplicador <= multiplicador >> 1;
                    contador      <= contador + {{(CW-1){1'b0}}, 1'b1};
                    if (ultimoPaso) begin
                        producto <= productoFinal;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_subsistema_multiplicacion.sv
// tb/tb_subsistema_multiplicacion.sv - self-checking bench for subsistema_multiplicacion

`timescale 1ns/1ps

module tb_subsistema_multiplicacion;

    localparam int ANCHO = 4;

    logic             reloj = 1'b0;
    logic             reinicio;
    logic [ANCHO-1:0] operandoA;
    logic [ANCHO-1:0] operandoB;
    logic             banderaValida;
    logic             iniciarMultiplicacion;
    logic [2*ANCHO-1:0] producto;
    logic             banderaListo;
    logic             ocupado;

    int checks = 0;
    int errors = 0;
    logic [2*ANCHO-1:0] ultimoEsperado;

    subsistema_multiplicacion #(.ANCHO(ANCHO)) dut (
        .reloj                 (reloj),
        .reinicio              (reinicio),
        .operandoA             (operandoA),
        .operandoB             (operandoB),
        .banderaValida         (banderaValida),
        .iniciarMultiplicacion (iniciarMultiplicacion),
        .producto              (producto),
        .banderaListo          (banderaListo),
        .ocupado               (ocupado)
    );

    always #5 reloj = ~reloj;

    // Reference product from plain integer arithmetic
    function automatic logic [2*ANCHO-1:0] modelo(input logic [ANCHO-1:0] a, input logic [ANCHO-1:0] b);
        int va;
        int vb;
        int r;
        va = int'(a);
        vb = int'(b);
`ifdef MULT_CON_SIGNO_EN
        if (a[ANCHO-1]) va = va - (1 << ANCHO);
        if (b[ANCHO-1]) vb = vb - (1 << ANCHO);
`endif
        r = va * vb;
        return r[2*ANCHO-1:0];
    endfunction

    task automatic ciclo();
        @(posedge reloj);
        #1;
    endtask

    // Full run with latency/hold checks; optionally scrambles inputs mid-calculation
    task automatic ejecutar(input logic [ANCHO-1:0] a, input logic [ANCHO-1:0] b,
                            input bit perturbar, input string nombre);
        logic [2*ANCHO-1:0] esperado;
        esperado = modelo(a, b);
        operandoA = a;
        operandoB = b;
        banderaValida = 1'b1;
        iniciarMultiplicacion = 1'b1;
        ciclo();
        for (int k = 1; k < ANCHO + 1; k++) begin
            checks++;
            if (ocupado !== 1'b1 || banderaListo !== 1'b0 || producto !== ultimoEsperado) begin
                errors++;
                $display("FAIL %s busy step%0d: ocupado=%b listo=%b producto=%h required 1 0 %h",
                         nombre, k, ocupado, banderaListo, producto, ultimoEsperado);
            end
            if (perturbar) begin
                operandoA = ANCHO'($urandom);
                operandoB = ANCHO'($urandom);
                banderaValida = 1'($urandom);
                iniciarMultiplicacion = 1'($urandom);
            end
            ciclo();
        end
        checks++;
        if (banderaListo !== 1'b1 || ocupado !== 1'b0 || producto !== esperado) begin
            errors++;
            $display("FAIL %s result %h*%h: producto=%h listo=%b ocupado=%b required %h 1 0",
                     nombre, a, b, producto, banderaListo, ocupado, esperado);
        end
        ultimoEsperado = esperado;
        iniciarMultiplicacion = 1'b0;
        ciclo();
        checks++;
        if (banderaListo !== 1'b0 || ocupado !== 1'b0 || producto !== esperado) begin
            errors++;
            $display("FAIL %s release: producto=%h listo=%b ocupado=%b required %h 0 0",
                     nombre, producto, banderaListo, ocupado, esperado);
        end
    endtask

    task automatic test_reset();
        reinicio = 1'b0;
        operandoA = '0;
        operandoB = '0;
        banderaValida = 1'b0;
        iniciarMultiplicacion = 1'b0;
        ciclo();
        ciclo();
        checks++;
        if (producto !== '0 || banderaListo !== 1'b0 || ocupado !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: producto=%h listo=%b ocupado=%b required 00 0 0",
                     producto, banderaListo, ocupado);
        end
        ultimoEsperado = '0;
        reinicio = 1'b1;
        banderaValida = 1'b1;
        operandoA = 4'd6;
        operandoB = 4'd6;
        for (int i = 0; i < 3; i++) begin
            ciclo();
            checks++;
            if (ocupado !== 1'b0 || banderaListo !== 1'b0 || producto !== '0) begin
                errors++;
                $display("FAIL idle_after_reset: ocupado=%b listo=%b producto=%h required 0 0 00",
                         ocupado, banderaListo, producto);
            end
        end
    endtask

    task automatic test_basic();
        ejecutar(4'd3, 4'd5, 1'b0, "basic_3x5");
    endtask

    task automatic test_extremes();
`ifdef MULT_CON_SIGNO_EN
        ejecutar(4'h8, 4'h8, 1'b0, "signed_m8xm8");
        ejecutar(4'h8, 4'h7, 1'b0, "signed_m8x7");
        ejecutar(4'hF, 4'h1, 1'b0, "signed_m1x1");
`else
        ejecutar(4'd15, 4'd15, 1'b0, "ext_15x15");
        ejecutar(4'd0, 4'd9, 1'b0, "ext_0x9");
        ejecutar(4'd9, 4'd1, 1'b0, "ext_9x1");
`endif
    endtask

    task automatic test_gating();
        operandoA = 4'd5;
        operandoB = 4'd5;
        banderaValida = 1'b0;
        iniciarMultiplicacion = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ciclo();
            checks++;
            if (ocupado !== 1'b0 || banderaListo !== 1'b0) begin
                errors++;
                $display("FAIL gate_valid_low: ocupado=%b listo=%b required 0 0", ocupado, banderaListo);
            end
        end
        iniciarMultiplicacion = 1'b0;
        ciclo();
        ejecutar(4'd6, 4'd7, 1'b1, "frozen_operands");
    endtask

    task automatic test_hold_start();
        logic [2*ANCHO-1:0] esperado;
        esperado = modelo(4'd4, 4'd3);
        operandoA = 4'd4;
        operandoB = 4'd3;
        banderaValida = 1'b1;
        iniciarMultiplicacion = 1'b1;
        for (int i = 0; i < ANCHO + 1; i++) ciclo();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (banderaListo !== 1'b1 || ocupado !== 1'b0 || producto !== esperado) begin
                errors++;
                $display("FAIL hold_start cycle%0d: listo=%b ocupado=%b producto=%h required 1 0 %h",
                         i, banderaListo, ocupado, producto, esperado);
            end
            ciclo();
        end
        iniciarMultiplicacion = 1'b0;
        ciclo();
        ultimoEsperado = esperado;
        checks++;
        if (banderaListo !== 1'b0 || ocupado !== 1'b0) begin
            errors++;
            $display("FAIL hold_start_release: listo=%b ocupado=%b required 0 0", banderaListo, ocupado);
        end
    endtask

    task automatic test_reset_mid();
        operandoA = 4'd7;
        operandoB = 4'd7;
        banderaValida = 1'b1;
        iniciarMultiplicacion = 1'b1;
        ciclo();
        ciclo();
        reinicio = 1'b0;
        ciclo();
        checks++;
        if (producto !== '0 || banderaListo !== 1'b0 || ocupado !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_op: producto=%h listo=%b ocupado=%b required 00 0 0",
                     producto, banderaListo, ocupado);
        end
        ultimoEsperado = '0;
        reinicio = 1'b1;
        iniciarMultiplicacion = 1'b0;
        ciclo();
        ejecutar(4'd2, 4'd3, 1'b0, "after_reset_2x3");
    endtask

    task automatic test_random();
        for (int n = 0; n < 30; n++) begin
            ejecutar(ANCHO'($urandom), ANCHO'($urandom), 1'($urandom), "random");
        end
    endtask

    task automatic test_back_to_back();
        ejecutar(4'd11, 4'd13, 1'b0, "b2b_first");
        ejecutar(4'd12, 4'd2, 1'b0, "b2b_second");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_gating();
        test_hold_start();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/subsistema_multiplicacion.md
# subsistema_multiplicacion

Sequential shift-and-add multiplier that directly consumes the operand pair and valid flag produced by the read subsystem. It captures two ANCHO-bit operands on a qualified start request and iterates one partial-product step per clock. It presents a 2·ANCHO-bit product with a ready flag to the display/result stage. It also holds off new requests while a multiplication is in flight.

## Interface
- ANCHO, 4, operand width in bits; product width is 2·ANCHO
- reloj  input  1  system clock; all state changes on rising edge
- reinicio  input  1  reset, synchronous, active-low (0 = reset)
- operandoA  input  ANCHO  multiplicand from read subsystem
- operandoB  input  ANCHO  multiplier from read subsystem
- banderaValida  input  1  operands valid (from read subsystem)
- iniciarMultiplicacion  input  1  start request, level-sensitive
- producto  output  2·ANCHO  registered result
- banderaListo  output  1  high while producto holds a fresh result
- ocupado  output  1  high while a multiplication is in progress

## Operation
- States: ESPERA, CALCULO, LISTO.
- ESPERA → CALCULO when iniciarMultiplicacion=1 and banderaValida=1 at a clock edge.
  - The same edge registers operandoA/operandoB internally.
  - It clears the accumulator and sets the step counter to 0.
  - With either input 0, the state stays ESPERA.
- CALCULO steps:
  - Each edge: if the current LSB of the shifted multiplier is 1, add the shifted multiplicand to the accumulator.
  - Then shift the multiplicand left, shift the multiplier right, and increment the counter.
  - The edge on which counter = ANCHO-1 performs the final step, loads producto, and moves to LISTO.
- LISTO → ESPERA on the first edge with iniciarMultiplicacion=0. While start stays high, the block remains in LISTO, so a held level causes no retrigger.
- Width rules:
  - The accumulator is 2·ANCHO bits; overflow is impossible.
  - Unsigned by default: 15×15 = 225 = 8'hE1.
- Ignored inputs:
  - Operand changes, banderaValida drops and start requests during CALCULO or LISTO.
  - Captured operands stay frozen until the next ESPERA → CALCULO transition.
- Output decoding:
  - ocupado = 1 exactly in CALCULO.
  - banderaListo = 1 exactly in LISTO.
- producto holds its last value in ESPERA and CALCULO, and is updated only on entry to LISTO.

## Timing
- Reset (reinicio=0 at an edge) is valid in any state, including mid-CALCULO. The operation is aborted with no partial result. After that edge:
  - state = ESPERA
  - producto = 0
  - banderaListo = 0
  - ocupado = 0
  - counter and accumulator = 0
- Start sampled at edge E0:
  - ocupado = 1 after E0.
  - Steps occur on edges E1..E_ANCHO.
  - banderaListo = 1 and producto valid after edge E_ANCHO.
  - Latency = ANCHO clocks (4 by default) from the sampling edge.
- Start and reset high/low simultaneously: reset wins.
- Minimum back-to-back spacing = ANCHO + 2 clocks: start must go low for ≥1 edge in LISTO.
- No combinational path from inputs to outputs; all outputs are registered or decoded from state registers.

## Configuration
- MULT_CON_SIGNO_EN defined:
  - Operands are ANCHO-bit two's complement.
  - At capture, each operand is replaced by its magnitude and the sign XOR is stored.
  - At the final step, the accumulator is negated if the XOR is 1.
  - producto is a 2·ANCHO-bit two's complement result.
  - Examples: −8×−8 = 64 = 8'h40; −8×7 = −56 = 8'hC8.
  - Latency is unchanged.
- MULT_CON_SIGNO_EN undefined: purely unsigned operation, with no sign logic synthesized.

## Test plan
- Reset values: hold reinicio=0 for 2 edges → producto=0, banderaListo=0, ocupado=0. Release and keep start=0 → the block stays idle.
- Basic unsigned:
  - A=4'd3, B=4'd5, banderaValida=1, start=1 at E0 → ocupado high during E1..E3.
  - After E4: producto=8'd15, banderaListo=1.
  - Drop start → ESPERA next edge, producto stays 15.
- Extremes (unsigned):
  - 15×15 → 8'hE1.
  - 0×9 → 8'h00.
  - 9×1 → 8'h09.
- Gating:
  - start=1 with banderaValida=0 → no transition.
  - Change A/B mid-CALCULO → result reflects the captured operands.
  - Start held high through LISTO → no second run.
- Reset mid-op: assert reinicio=0 at E2 of a 7×7 run → all outputs 0 next edge. A new 2×3 run then yields 8'd6 with full latency.
- Signed build (MULT_CON_SIGNO_EN):
  - −8×−8 → 8'h40.
  - −8×7 → 8'hC8.
  - −1×1 → 8'hFF.
  - Latency 4 for all three.
